// File: rtl/hex_disp_pkg.sv
// Shared types, constants and the hexadecimal glyph table for the multi-digit HEX driver.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_ZBLANK = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_SCROLL = 2'b11
    } mode_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SCROLL = 1'b1
    } state_e;

    // Active-low segments: all ones means every segment is dark
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] seg_of(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational single-digit decoder: nibble plus enable to active-low segments.
module hex_seg_decode
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       enable,
    output logic [6:0] seg
);

    // A disabled digit is driven fully dark regardless of its nibble
    always_comb begin
        seg = enable ? seg_of(nibble) : SEG_OFF;
    end

endmodule

// File: rtl/hex_multi_display.sv
// N-digit hex display driver with load/ready capture and static, zero-blank,
// blink and scroll-in display modes. All outputs come straight from flops.
module hex_multi_display
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int SCROLL_DIV = 12_500_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic [4*NUM_DIGITS-1:0]      data,
    input  logic [1:0]                   mode,
    output logic                         ready,
    output logic [NUM_DIGITS-1:0][6:0]   HEX
);

    localparam int BW  = $clog2(BLINK_DIV);
    localparam int SW  = $clog2(SCROLL_DIV);
    localparam int STW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef logic [NUM_DIGITS-1:0][3:0] nib_vec_t;

    state_e                    state_q, state_d;
    nib_vec_t                  value_q, value_d;
    mode_e                     mode_q, mode_d;
    nib_vec_t                  img_q, img_d;
    logic [NUM_DIGITS-1:0]     mask_q, mask_d;
    logic [BW-1:0]             blink_cnt_q, blink_cnt_d;
    logic                      phase_q, phase_d;
    logic [SW-1:0]             scroll_cnt_q, scroll_cnt_d;
    logic [STW-1:0]            step_q, step_d;
    logic                      ready_q, ready_d;
    logic [NUM_DIGITS-1:0][6:0] hex_q, hex_d;

    nib_vec_t                  data_nib;
    logic [NUM_DIGITS-1:0]     zb_mask;
    logic [3:0]                next_nib;
    logic                      accept;
    logic                      blank_all;

    assign data_nib = data;

    // Leading-zero mask: a digit shows once any nibble at or above it is nonzero; digit 0 always shows
    always_comb begin
        logic seen;
        seen    = 1'b0;
        zb_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen       = seen | (data_nib[i] != 4'h0);
            zb_mask[i] = seen | (i == 0);
        end
    end

    // Next-state logic: capture handshake, blink timer, scroll FSM and the displayed image
    always_comb begin
        state_d      = state_q;
        value_d      = value_q;
        mode_d       = mode_q;
        img_d        = img_q;
        mask_d       = mask_q;
        blink_cnt_d  = blink_cnt_q;
        phase_d      = phase_q;
        scroll_cnt_d = scroll_cnt_q;
        step_d       = step_q;
        next_nib     = 4'h0;
        accept       = load && ready_q;

        // Blink timer free-runs; restarting it on every load makes a new value appear immediately
        if (accept) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        // Nibble entering on the next scroll step: most significant first
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (step_q == STW'(NUM_DIGITS - 1 - i)) begin
                next_nib = value_q[i];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    value_d      = data_nib;
                    mode_d       = mode_e'(mode);
                    scroll_cnt_d = '0;
                    step_d       = '0;
                    if (mode_e'(mode) == MODE_SCROLL) begin
                        state_d = S_SCROLL;
                        img_d   = '0;
                        mask_d  = '0;
                    end else begin
                        img_d  = data_nib;
                        mask_d = (mode_e'(mode) == MODE_ZBLANK) ? zb_mask : '1;
                    end
                end
            end
            S_SCROLL: begin
                if (scroll_cnt_q == SW'(SCROLL_DIV - 1)) begin
                    scroll_cnt_d = '0;
                    img_d[0]     = next_nib;
                    mask_d[0]    = 1'b1;
                    for (int i = 1; i < NUM_DIGITS; i++) begin
                        img_d[i]  = img_q[i-1];
                        mask_d[i] = mask_q[i-1];
                    end
                    if (step_q == STW'(NUM_DIGITS - 1)) begin
                        state_d = S_IDLE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end else begin
                    scroll_cnt_d = scroll_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d   = (state_d == S_IDLE);
        blank_all = (mode_d == MODE_BLINK) && phase_d;
    end

    // One decoder per digit, fed from next-state so HEX lands together with the state it shows
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            hex_seg_decode u_dec (
                .nibble (img_d[gi]),
                .enable (mask_d[gi] & ~blank_all),
                .seg    (hex_d[gi])
            );
        end
    endgenerate

    // State and output registers; reset blanks every digit and opens the handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            value_q      <= '0;
            mode_q       <= MODE_STATIC;
            img_q        <= '0;
            mask_q       <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            scroll_cnt_q <= '0;
            step_q       <= '0;
            ready_q      <= 1'b1;
            hex_q        <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            mode_q       <= mode_d;
            img_q        <= img_d;
            mask_q       <= mask_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            scroll_cnt_q <= scroll_cnt_d;
            step_q       <= step_d;
            ready_q      <= ready_d;
            hex_q        <= hex_d;
        end
    end

    assign ready = ready_q;
    assign HEX   = hex_q;

endmodule

// File: tb/tb_hex_multi_display.sv
// Self-checking bench for hex_multi_display with a cycle-count based reference model.
module tb_hex_multi_display;

    localparam int N    = 4;
    localparam int BDIV = 4;
    localparam int SDIV = 3;

    typedef logic [N-1:0][6:0] hex_t;
    localparam hex_t ALL_OFF = {N{7'h7F}};

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] data  = '0;
    logic [1:0]  mode  = 2'b00;
    logic        ready;
    hex_t        hex;

    int errors = 0;
    int checks = 0;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: last accepted value/mode and clock edges elapsed since that accept
    bit          m_valid = 1'b0;
    logic [15:0] m_value = '0;
    int          m_mode  = 0;
    int          m_t     = 0;

    always #5 clk = ~clk;

    hex_multi_display #(
        .NUM_DIGITS (N),
        .BLINK_DIV  (BDIV),
        .SCROLL_DIV (SDIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .data  (data),
        .mode  (mode),
        .ready (ready),
        .HEX   (hex)
    );

    function automatic bit exp_ready();
        return !m_valid || (m_mode != 3) || (m_t >= N * SDIV);
    endfunction

    function automatic hex_t exp_hex();
        hex_t       r;
        int         s;
        bit         show;
        logic [3:0] nib;
        r = ALL_OFF;
        for (int i = 0; i < N; i++) begin
            show = 1'b0;
            nib  = m_value[4*i +: 4];
            if (m_valid) begin
                case (m_mode)
                    0: show = 1'b1;
                    1: show = (i == 0) || ((m_value >> (4 * i)) != 16'h0);
                    2: show = ((m_t / BDIV) % 2) == 0;
                    default: begin
                        s = m_t / SDIV;
                        if (s > N) s = N;
                        show = (i < s);
                        if (show) nib = m_value[4*(N - s + i) +: 4];
                    end
                endcase
            end
            if (show) r[i] = glyph[nib];
        end
        return r;
    endfunction

    function automatic hex_t img_of(input logic [15:0] v);
        hex_t r;
        for (int i = 0; i < N; i++) r[i] = glyph[v[4*i +: 4]];
        return r;
    endfunction

    // Advance one clock, update the model, and leave time 1 unit past the edge
    task automatic tick();
        bit acc;
        acc = reset && load && exp_ready();
        @(posedge clk);
        if (!reset) begin
            m_valid = 1'b0;
            m_t     = 0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_value = data;
            m_mode  = int'(mode);
            m_t     = 0;
        end else begin
            m_t++;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; load = 1'b1; data = 16'hFFFF; mode = 2'b00;
        repeat (3) tick();
        checks++;
        if (hex !== ALL_OFF) begin errors++; $display("FAIL reset_hold_hex got=%h exp=%h", hex, ALL_OFF); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_hold_ready got=%b exp=1", ready); end
        reset = 1'b1; load = 1'b0;
        tick();
        checks++;
        if (hex !== ALL_OFF) begin errors++; $display("FAIL reset_release_hex got=%h exp=%h", hex, ALL_OFF); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", ready); end
        $display("reset: hex=%h ready=%b", hex, ready);
    endtask

    task automatic test_static();
        hex_t want;
        data = 16'h1A2F; mode = 2'b00; load = 1'b1;
        tick();
        load = 1'b0;
        want = {7'h79, 7'h08, 7'h24, 7'h0E};
        checks++;
        if (hex !== want) begin errors++; $display("FAIL static_1A2F got=%h exp=%h", hex, want); end
        $display("static load 1A2F: hex=%h", hex);
        for (int n = 0; n < 16; n++) begin
            data = {12'($urandom), 4'(n)}; mode = 2'b00; load = 1'b1;
            tick();
            load = 1'b0;
            checks++;
            if (hex[0] !== glyph[n]) begin errors++; $display("FAIL glyph_%0d got=%h exp=%h", n, hex[0], glyph[n]); end
            checks++;
            if (hex !== exp_hex()) begin errors++; $display("FAIL static_sweep data=%h got=%h exp=%h", data, hex, exp_hex()); end
            $display("static sweep data=%h hex=%h", data, hex);
        end
    endtask

    task automatic test_zblank();
        logic [15:0] v;
        data = 16'h00B0; mode = 2'b01; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (hex !== {7'h7F, 7'h7F, 7'h03, 7'h40}) begin errors++; $display("FAIL zblank_00B0 got=%h exp=%h", hex, {7'h7F, 7'h7F, 7'h03, 7'h40}); end
        $display("zblank load 00B0: hex=%h", hex);
        data = 16'h0000; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (hex !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin errors++; $display("FAIL zblank_0000 got=%h exp=%h", hex, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
        $display("zblank load 0000: hex=%h", hex);
        for (int k = 0; k < 10; k++) begin
            v = 16'($urandom);
            for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) v[4*i +: 4] = 4'h0;
            data = v; load = 1'b1;
            tick();
            load = 1'b0;
            checks++;
            if (hex !== exp_hex()) begin errors++; $display("FAIL zblank_rand data=%h got=%h exp=%h", v, hex, exp_hex()); end
            $display("zblank load %h: hex=%h", v, hex);
        end
    endtask

    task automatic test_blink();
        hex_t want;
        data = 16'h1234; mode = 2'b10; load = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            want = (c <= 4 || c > 8) ? img_of(16'h1234) : ALL_OFF;
            checks++;
            if (hex !== want) begin errors++; $display("FAIL blink_cycle_%0d got=%h exp=%h", c, hex, want); end
            $display("blink cycle %0d: hex=%h", c, hex);
            if (c < 10) tick();
        end
        // Now in visible cycle 10; step into the next blank phase then reload
        repeat (4) tick();
        checks++;
        if (hex !== ALL_OFF) begin errors++; $display("FAIL blink_blank_phase got=%h exp=%h", hex, ALL_OFF); end
        data = 16'hBEEF; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (hex !== img_of(16'hBEEF)) begin errors++; $display("FAIL blink_reload got=%h exp=%h", hex, img_of(16'hBEEF)); end
        $display("blink reload BEEF: hex=%h", hex);
    endtask

    task automatic test_scroll();
        int busy;
        data = 16'h1234; mode = 2'b11; load = 1'b1;
        tick();
        load = 1'b0;
        busy = (ready == 1'b0) ? 1 : 0;
        checks++;
        if (hex !== ALL_OFF) begin errors++; $display("FAIL scroll_entry got=%h exp=%h", hex, ALL_OFF); end
        for (int c = 1; c <= 12; c++) begin
            if (c == 6) begin data = 16'hFFFF; mode = 2'b00; load = 1'b1; end
            if (c == 7) load = 1'b0;
            tick();
            if (ready == 1'b0) busy++;
            checks++;
            if (hex !== exp_hex() || ready !== exp_ready()) begin
                errors++;
                $display("FAIL scroll_cycle_%0d got=%h/%b exp=%h/%b", c, hex, ready, exp_hex(), exp_ready());
            end
            if (c == 3) begin
                checks++;
                if (hex !== {7'h7F, 7'h7F, 7'h7F, 7'h79}) begin errors++; $display("FAIL scroll_first_step got=%h exp=%h", hex, {7'h7F, 7'h7F, 7'h7F, 7'h79}); end
            end
            $display("scroll cycle %0d: hex=%h ready=%b", c, hex, ready);
        end
        checks++;
        if (busy != 12) begin errors++; $display("FAIL scroll_busy got=%0d exp=12", busy); end
        checks++;
        if (hex !== img_of(16'h1234) || ready !== 1'b1) begin errors++; $display("FAIL scroll_done got=%h/%b exp=%h/1", hex, ready, img_of(16'h1234)); end
    endtask

    task automatic test_back_to_back();
        int  waited;
        bit  seen;
        data = 16'h4321; mode = 2'b11; load = 1'b1;
        tick();
        data = 16'h0C0D; mode = 2'b00;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 30) begin
            tick();
            waited++;
            if (ready === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL b2b_ready_timeout got=%0d cycles exp=12", waited); end
        checks++;
        if (hex !== img_of(16'h4321)) begin errors++; $display("FAIL b2b_scroll_image got=%h exp=%h", hex, img_of(16'h4321)); end
        tick();
        load = 1'b0;
        checks++;
        if (hex !== {7'h40, 7'h46, 7'h40, 7'h21} || ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_new_value got=%h/%b exp=%h/1", hex, ready, {7'h40, 7'h46, 7'h40, 7'h21});
        end
        $display("back-to-back: waited=%0d hex=%h ready=%b", waited, hex, ready);
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            load = ($urandom_range(0, 9) < 3);
            data = 16'($urandom);
            mode = 2'($urandom);
            tick();
            checks++;
            if (hex !== exp_hex() || ready !== exp_ready()) begin
                errors++;
                $display("FAIL random_%0d got=%h/%b exp=%h/%b", k, hex, ready, exp_hex(), exp_ready());
            end
            $display("random %0d: load=%b data=%h mode=%0d hex=%h ready=%b", k, load, data, mode, hex, ready);
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid();
        data = 16'h5678; mode = 2'b11; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (7) tick();
        checks++;
        if (hex !== exp_hex()) begin errors++; $display("FAIL midscroll_before got=%h exp=%h", hex, exp_hex()); end
        reset = 1'b0;
        #1;
        m_valid = 1'b0;
        checks++;
        if (hex !== ALL_OFF || ready !== 1'b1) begin errors++; $display("FAIL midscroll_async_reset got=%h/%b exp=%h/1", hex, ready, ALL_OFF); end
        $display("reset mid-scroll: hex=%h ready=%b", hex, ready);
        tick();
        reset = 1'b1;
        data = 16'h9ABC; mode = 2'b10; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (5) tick();
        checks++;
        if (hex !== ALL_OFF) begin errors++; $display("FAIL midblink_blank got=%h exp=%h", hex, ALL_OFF); end
        reset = 1'b0;
        #1;
        m_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (hex !== ALL_OFF || ready !== 1'b1) begin errors++; $display("FAIL midblink_reset got=%h/%b exp=%h/1", hex, ready, ALL_OFF); end
        $display("reset mid-blink: hex=%h ready=%b", hex, ready);
    endtask

    initial begin
        test_reset();
        test_static();
        test_zblank();
        test_blink();
        test_scroll();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
